// File: rtl/inpass_pkg.sv
// Shared types and constants for the N-channel input pass BEL.
// Each channel takes a 2-bit mode from the configuration frame.
package inpass_pkg;

  localparam int CFG_BITS_PER_CH = 2;

  typedef enum logic [1:0] {
    MODE_COMB = 2'b00,
    MODE_REG  = 2'b01,
    MODE_SYNC = 2'b10,
    MODE_EDGE = 2'b11
  } mode_t;

endpackage

// File: rtl/inpass_channel.sv
// One input-pass channel: capture flop, synchroniser chain, edge detector and output mux.
// Build option INPASS_DEBOUNCE_EN adds a per-channel debounce stage after the synchroniser.
module inpass_channel
  import inpass_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 4
) (
  input  logic  UserCLK,
  input  logic  Reset,
  input  logic  I,
  input  mode_t Mode,
  output logic  O
);

  logic                   qReg;
  logic [SYNC_STAGES-1:0] syncReg;
  logic                   prevReg;
  logic                   syncLast;
  logic                   level;

  assign syncLast = syncReg[SYNC_STAGES-1];

  // Every flop runs in every mode so that a mode switch never needs a flush.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      qReg    <= 1'b0;
      syncReg <= '0;
      prevReg <= 1'b0;
    end else begin
      qReg    <= I;
      syncReg <= {syncReg[SYNC_STAGES-2:0], I};
      prevReg <= level;
    end
  end

`ifdef INPASS_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] cntReg;
  logic                  levelReg;

  // The level only follows the synchronised input after it has disagreed for 2^DEBOUNCE_W edges in a row.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      cntReg   <= '0;
      levelReg <= 1'b0;
    end else if (syncLast == levelReg) begin
      cntReg <= '0;
    end else if (&cntReg) begin
      levelReg <= syncLast;
      cntReg   <= '0;
    end else begin
      cntReg <= cntReg + 1'b1;
    end
  end

  assign level = levelReg;
`else
  assign level = syncLast;
`endif

  always_comb begin
    O = I;
    unique case (Mode)
      MODE_COMB: O = I;
      MODE_REG:  O = qReg;
      MODE_SYNC: O = level;
      MODE_EDGE: O = level & ~prevReg;
    endcase
  end

endmodule

// File: rtl/inpass_sync_frame_config.sv
// N-channel input pass BEL; each channel's mode comes from two frame ConfigBits.
// Optional debounce on the synchronised modes is enabled by defining INPASS_DEBOUNCE_EN.
module inpass_sync_frame_config
  import inpass_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int SYNC_STAGES  = 2,
  parameter  int DEBOUNCE_W   = 4,
  localparam int NoConfigBits = CFG_BITS_PER_CH * NUM_CH
) (
  input  logic                    UserCLK,
  input  logic                    Reset,
  input  logic [NUM_CH-1:0]       I,
  output logic [NUM_CH-1:0]       O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gCh
      mode_t chMode;

      assign chMode = mode_t'(ConfigBits[gi*CFG_BITS_PER_CH +: CFG_BITS_PER_CH]);

      inpass_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_W (DEBOUNCE_W)
      ) uChannel (
        .UserCLK(UserCLK),
        .Reset  (Reset),
        .I      (I[gi]),
        .Mode   (chMode),
        .O      (O[gi])
      );
    end
  endgenerate

endmodule
